// File: rtl/cnt_cmd_driver_if.sv
// Command/response bundle between a requester and cnt_cmd_driver.
// The requester is master; the driver is slave.
interface cnt_cmd_driver_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_load;
    logic [STEP_W-1:0] cmd_steps;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_count;
    logic [STEP_W-1:0] rsp_wraps;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_load, cmd_steps,
        input  cmd_ready, rsp_valid, rsp_count, rsp_wraps, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_load, cmd_steps,
        output cmd_ready, rsp_valid, rsp_count, rsp_wraps, rsp_err
    );
endinterface

// File: rtl/cnt_cmd_driver.sv
// Command-side sequencer for an up/down loadable counter: runs LOAD/UP/DOWN
// commands and reports final count and wrap count in a one-cycle response.
//
//   state  | meaning
//   IDLE   | hold counter (reload own value), accept commands
//   LOAD   | drive captured load value for one edge
//   RUN    | let the counter count; one edge per remaining step
//   DONE   | counter held, one-cycle response
module cnt_cmd_driver #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    cnt_cmd_driver_if.slave  cmd,
    output logic             cnt_rstn,
    output logic             cnt_load_en,
    output logic [WIDTH-1:0] cnt_load,
    output logic             cnt_down,
    input  logic [WIDTH-1:0] cnt_count,
    input  logic             cnt_rollover
);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  load_q;
    logic [STEP_W-1:0] remaining;
    logic [STEP_W-1:0] wraps;
    logic              err_q;
    logic              accept;
    logic              wrap_hit;

    assign cmd.cmd_ready = (state == S_IDLE) && cnt_rstn && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // cnt_rollover already flags all-ones, so only the down case needs a compare
    assign wrap_hit = ((op_q == OP_UP) && cnt_rollover) ||
                      ((op_q == OP_DOWN) && (cnt_count == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt_rstn  <= 1'b0;
            op_q      <= '0;
            load_q    <= '0;
            remaining <= '0;
            wraps     <= '0;
            err_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_rstn <= 1'b1;
            if (accept) begin
                op_q      <= cmd.cmd_op;
                load_q    <= cmd.cmd_load;
                remaining <= cmd.cmd_steps;
                wraps     <= '0;
                err_q     <= (cmd.cmd_op == 2'b11);
            end else if (state == S_RUN) begin
                remaining <= remaining - STEP_W'(1);
                if (wrap_hit)
                    wraps <= wraps + STEP_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_LOAD:        state_nxt = S_LOAD;
                        OP_UP, OP_DOWN: state_nxt = (cmd.cmd_steps == '0) ? S_DONE : S_RUN;
                        default:        state_nxt = S_DONE;
                    endcase
                end
            end
            S_LOAD:  state_nxt = S_DONE;
            S_RUN:   if (remaining == STEP_W'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter never free-runs outside RUN: it reloads its own value
    always_comb begin
        cnt_load_en = 1'b1;
        cnt_load    = cnt_count;
        cnt_down    = 1'b0;
        case (state)
            S_LOAD: cnt_load = load_q;
            S_RUN: begin
                cnt_load_en = 1'b0;
                cnt_down    = (op_q == OP_DOWN);
            end
            default: ;
        endcase
    end

    assign cmd.rsp_valid = (state == S_DONE);
    assign cmd.rsp_count = (state == S_DONE) ? cnt_count : '0;
    assign cmd.rsp_wraps = (state == S_DONE) ? wraps : '0;
    assign cmd.rsp_err   = (state == S_DONE) ? err_q : 1'b0;
endmodule

// File: doc/cnt_cmd_driver.md
Name: cnt_cmd_driver

Overview:
Command-side controller for the up/down loadable counter on the cnt_if bundle. It drives rstn, load_en, load and down, and it observes count and rollover. It accepts LOAD / UP-n / DOWN-n commands over a valid/ready handshake and holds the counter steady between commands. After each command it returns the final count and the number of wraps in a one-cycle response.

Parameters:
WIDTH, 4, counter width; must match the counter instance.
STEP_W, 8, width of the step-count field and of the wrap counter.

Ports:
clk  input  1  clock; the counter shares it.
rst  input  1  asynchronous reset, active-high.
cmd_valid  input  1  command present.
cmd_ready  output  1  driver can accept a command.
cmd_op  input  2  command opcode: 00 LOAD, 01 UP, 10 DOWN, 11 reserved.
cmd_load  input  WIDTH  value used by LOAD.
cmd_steps  input  STEP_W  number of count edges for UP/DOWN.
rsp_valid  output  1  one-cycle completion pulse.
rsp_count  output  WIDTH  counter value at completion.
rsp_wraps  output  STEP_W  number of wrap edges during the command.
rsp_err  output  1  set when the reserved opcode was accepted.
cnt_rstn  output  1  counter reset, active-low, registered.
cnt_load_en  output  1  to counter load_en.
cnt_load  output  WIDTH  to counter load.
cnt_down  output  1  to counter down.
cnt_count  input  WIDTH  from counter count.
cnt_rollover  input  1  from counter rollover (&count).

Behaviour:
- Reset (rst=1, async):
  - State goes to IDLE.
  - cnt_rstn=0, cmd_ready=0, rsp_valid=0, rsp_count=0, rsp_wraps=0, rsp_err=0.
  - Step and wrap registers clear.
- cnt_rstn rises on the first clk edge after rst deasserts.
- States are IDLE, LOAD, RUN, DONE.
  - IDLE: cmd_ready=1 when rst=0 and cnt_rstn=1. Hold the counter with cnt_load_en=1, cnt_load=cnt_count, cnt_down=0.
  - Accept a command on the edge where cmd_valid & cmd_ready; capture op, load and steps.
- Transitions on accept:
  - LOAD goes to LOAD.
  - UP/DOWN with steps>0 go to RUN with remaining=steps and wraps=0.
  - UP/DOWN with steps=0 go to DONE.
  - Reserved opcode goes to DONE with err=1; the counter is untouched.
- LOAD (one cycle): cnt_load_en=1, cnt_load=captured value. Next state is DONE.
- RUN:
  - Drive cnt_load_en=0 and cnt_down=(op==DOWN).
  - Decrement remaining on every edge; leave for DONE on the edge where remaining==1. Exactly `steps` count edges occur.
  - Per RUN cycle, wraps increments when (UP and cnt_count is all-ones) or (DOWN and cnt_count==0).
  - wraps ≤ steps, so no saturation is needed.
- DONE (one cycle):
  - Counter is held as in IDLE.
  - rsp_valid=1, rsp_count=cnt_count (post-operation value), rsp_wraps=wraps, rsp_err=err.
  - Next state is IDLE.
  - rsp has no backpressure.
- rsp_count, rsp_wraps and rsp_err are valid only while rsp_valid=1; they are driven to 0 otherwise.
- cmd_ready=0 in LOAD, RUN and DONE. Inputs there are ignored.
- Latency, with accept at edge E0:
  - LOAD: counter updated at E1, rsp_valid during E1–E2, cmd_ready high after E2.
  - UP/DOWN n: last count edge at En, rsp during En–En+1.
  - steps=0 or reserved: rsp during E0–E1.
- Counter arithmetic wraps modulo 2^WIDTH. No saturation.
- rst mid-operation: abort immediately. No rsp_valid is issued, cnt_rstn=0 forces the counter to 0, and the captured command is discarded.
- The cnt_* outputs depend only on state, captured registers and cnt_count. There is no path from cmd_valid to the cnt_* outputs.

Test Plan:
- Reset: hold rst=1 for 3 clocks → cnt_rstn=0, cmd_ready=0, rsp_valid=0, counter=0. Release → cnt_rstn=1 after one edge; count stays 0 for 10 idle cycles.
- LOAD 0xA → rsp_valid one cycle after the load edge, rsp_count=0xA, rsp_wraps=0, rsp_err=0; count stays 0xA for 10 idle cycles.
- LOAD 0xE, then UP 3 → exactly 3 count edges, rsp_count=0x1, rsp_wraps=1.
- LOAD 0x1, then DOWN 20 → rsp_count=0xD, rsp_wraps=2, and cmd_ready=0 for the whole run.
- UP 0 from count 0x5 → rsp in the cycle after accept, rsp_count=0x5, rsp_wraps=0. Opcode 11 → rsp_err=1, count unchanged at 0x5.
- UP 100 with rst pulsed after 5 steps → no rsp_valid, count=0, cnt_rstn low. After release, LOAD 0x3 → rsp_count=0x3.
